// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate format codes and a small decode helper
// for the immediate generator pipeline.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  // OP-IMM / OP-IMM-32 funct3 values 001 (SLLI) and 101 (SRLI/SRAI) are shifts.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Purely combinational immediate decoder: extracts and extends the immediate
// of one instruction word and classifies its format.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];

  // Sign-extend a 12-bit field (I/S formats).
  function automatic logic [XLEN-1:0] sext12(input logic signed [11:0] v);
    return XLEN'(v);
  endfunction

  // Sign-extend a 13-bit byte offset (B format).
  function automatic logic [XLEN-1:0] sext13(input logic signed [12:0] v);
    return XLEN'(v);
  endfunction

  // Sign-extend a 21-bit byte offset (J format).
  function automatic logic [XLEN-1:0] sext21(input logic signed [20:0] v);
    return XLEN'(v);
  endfunction

  // Sign-extend a 32-bit upper immediate (U format), sign-filling on RV64.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Zero-extend a shift amount or CSR zimm field.
  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  // Opcode-driven format selection and immediate assembly.
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        imm = sext12(instr[31:20]);
        fmt = FMT_I;
      end
      OPC_OPIMM: begin
        if (is_shift(funct3)) begin
          // Only the shamt field is passed; funct7/funct6 bits are masked off.
          imm = RV64 ? zext6(instr[25:20]) : zext6({1'b0, instr[24:20]});
          fmt = FMT_SHAMT;
        end else begin
          imm = sext12(instr[31:20]);
          fmt = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (RV64) begin
          if (is_shift(funct3)) begin
            imm = zext6({1'b0, instr[24:20]});
            fmt = FMT_SHAMT;
          end else begin
            imm = sext12(instr[31:20]);
            fmt = FMT_I;
          end
        end
      end
      OPC_STORE: begin
        imm = sext12({instr[31:25], instr[11:7]});
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        fmt = FMT_B;
      end
      OPC_JAL: begin
        imm = sext21({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
        fmt = FMT_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = sext32({instr[31:12], 12'h000});
        fmt = FMT_U;
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          imm = zext6({1'b0, instr[19:15]});
          fmt = FMT_ZIMM;
        end
      end
      default: begin
        imm = '0;
        fmt = FMT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle registered output with a
// two-entry (main + skid) buffer for full throughput under back-pressure,
// and a flush that kills all held entries.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;

  logic            m_valid_q, m_valid_d;
  logic [XLEN-1:0] m_imm_q,   m_imm_d;
  fmt_e            m_fmt_q,   m_fmt_d;
  logic            s_valid_q, s_valid_d;
  logic [XLEN-1:0] s_imm_q,   s_imm_d;
  fmt_e            s_fmt_q,   s_fmt_d;

  logic accept;
  logic m_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  // Skid slot occupancy alone gates acceptance; reset holds it off.
  assign in_ready  = rst_n && !s_valid_q;
  assign accept    = in_valid && in_ready;
  assign m_free    = !m_valid_q || out_ready;

  assign out_valid = m_valid_q;
  assign out_imm   = m_imm_q;
  assign out_fmt   = m_fmt_q;

  // Next-state for main and skid slots; flush wins over any transfer.
  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_fmt_d   = m_fmt_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_fmt_d   = s_fmt_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        // Older skid entry moves forward first to keep FIFO order.
        m_valid_d = 1'b1;
        m_imm_d   = s_imm_q;
        m_fmt_d   = s_fmt_q;
        s_valid_d = accept;
        if (accept) begin
          s_imm_d = dec_imm;
          s_fmt_d = dec_fmt;
        end
      end else begin
        m_valid_d = accept;
        if (accept) begin
          m_imm_d = dec_imm;
          m_fmt_d = dec_fmt;
        end
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_imm_d   = dec_imm;
      s_fmt_d   = dec_fmt;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_fmt_q   <= FMT_NONE;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_fmt_q   <= FMT_NONE;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_fmt_q   <= m_fmt_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_fmt_q   <= s_fmt_d;
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined RISC-V immediate generator for the decode stage. It accepts one instruction word per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate at XLEN width, together with a format code. Output is registered, with one cycle of latency. A two-entry skid buffer sustains full throughput under back-pressure, and a flush input kills in-flight entries on redirect. It supersedes the combinational immediate extender by adding RV64 shifts, CSR zimm, byte-offset B/J immediates and flow control.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- RV64, (XLEN==64): derived localparam. Enables 6-bit shamt for OP-IMM and decodes OP-IMM-32.
- clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- flush  in  1  kills all held entries at the next edge
- in_valid  in  1  in_instr is valid
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  instruction word
- out_valid  out  1  out_imm / out_fmt are valid
- out_ready  in  1  consumer accepts this cycle
- out_imm  out  XLEN  extended immediate, in bytes for B/J
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM

## Operation
- Decode uses opcode instr[6:0]:
  - LOAD 0000011, JALR 1100111, OP-IMM 0010011 (non-shift): I format, sext(instr[31:20]).
  - OP-IMM with funct3 001/101: SHAMT format, zero-extended shamt. Shamt is instr[24:20] when RV64=0, instr[25:20] when RV64=1. funct7/funct6 bits never reach out_imm.
  - OP-IMM-32 0011011, RV64 only: shifts give SHAMT from instr[24:20]; others give I. When RV64=0 this opcode gives NONE.
  - STORE 0100011: S format, sext({instr[31:25],instr[11:7]}).
  - BRANCH 1100011: B format, sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - JAL 1101111: J format, sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - LUI 0110111, AUIPC 0010111: U format, sext({instr[31:12],12'h000}). Upper bits are sign-filled when XLEN=64.
  - SYSTEM 1110011 with funct3[2]=1: ZIMM format, zero-extended instr[19:15]. Other SYSTEM encodings give NONE.
  - Any other opcode: NONE, out_imm=0.
- Flow control:
  - Accept when in_valid && in_ready. Decode is combinational on in_instr; the result is captured at the edge.
  - Main register M drives the outputs. Skid register S holds a decoded result when M is held by out_ready=0.
  - in_ready = Reset && !S_valid (combinational).
  - Order is strictly FIFO; no entry is dropped or duplicated.
  - Edge update, when not flushing and not in reset:
    - If M is empty or out_ready=1, M loads from S if S is valid, otherwise from the accepted input.
    - If S was valid and an accept also occurs in that cycle, the accepted input goes into S.
    - If M stays held and an accept occurs, the input goes into S.
- flush=1: M_valid and S_valid clear at the edge. An input accepted in the same cycle is discarded. Flush has priority over accept and output transfer.

## Timing
- Reset (Reset=0 at an edge): out_valid=0, out_imm=0, out_fmt=0 (NONE), S cleared. in_ready=0 while Reset is low, and 1 in the first cycle after release.
- Latency is 1 cycle: an input accepted at edge N appears on the outputs after edge N.
- Throughput is 1 per cycle while out_ready=1.
- Stall: out_ready held low absorbs one extra accept into S, then in_ready drops. When out_ready rises, S drains to M in one cycle, and in_ready returns high in that same cycle after the edge.
- out_imm and out_fmt stay stable while out_valid && !out_ready.
- Reset in mid-stream drops all entries with no partial output.

## Structure
- Package imm_gen_pkg holds:
  - opcode constants: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM
  - the 3-bit fmt enum: FMT_NONE through FMT_ZIMM
- Sub-module imm_decode: purely combinational, parameter XLEN, input instr, outputs imm and fmt.
- Top level holds the M/S registers and handshake logic only.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_imm=0xFFFFFFFF, out_fmt=I.
- XLEN=32, 0x41F0D093 (srai x1,x1,31) -> out_imm=0x0000001F, out_fmt=SHAMT. funct7 bit 30 does not leak.
- XLEN=32, 0xFE000EE3 (beq -4) -> 0xFFFFFFFC / B. Then 0x123450B7 (lui) -> 0x12345000 / U on the next cycle.
- XLEN=64, 0x03F09093 (slli shamt 63) -> 0x000000000000003F / SHAMT. Then 0x300FD073 (csrrwi zimm 31) -> 0x1F / ZIMM. Then 0x80000037 (lui) -> 0xFFFFFFFF80000000 / U.
- Back-pressure: send 4 instructions back-to-back with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts. After release, all 4 results emerge in order with none lost.
- Flush with M and S both valid and in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed-cycle input never appears.
